// File: rtl/cpu_bus_monitor_if.sv
// Snoop and trace-drain bundle for cpu_bus_monitor.
// The cpu side (master) drives the write strobe, address, data and the trace
// pop request; the monitor (slave) returns the trace FIFO head and status.
// CNT_W must equal $clog2(TRACE_DEPTH + 1) of the attached monitor.
interface cpu_bus_monitor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
);

  logic              wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] w_data;

  logic              trace_rd;
  logic              trace_valid;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;
  logic [CNT_W-1:0]  trace_count;
  logic              trace_ovf;

  modport master (
    output wr_en,
    output mem_addr,
    output w_data,
    output trace_rd,
    input  trace_valid,
    input  trace_addr,
    input  trace_data,
    input  trace_count,
    input  trace_ovf
  );

  modport slave (
    input  wr_en,
    input  mem_addr,
    input  w_data,
    input  trace_rd,
    output trace_valid,
    output trace_addr,
    output trace_data,
    output trace_count,
    output trace_ovf
  );

endinterface

// File: rtl/cpu_bus_monitor.sv
// Self-check monitor beside the cpu data bus.
// Snoops data-memory writes, ends the test on a mailbox write (PASS when the
// mailbox data equals PASS_VALUE, otherwise the data is reported as fail_code),
// flags a timeout after TIMEOUT_CYC enabled cycles, and keeps a
// first-word-fall-through trace FIFO of recent writes drained via trace_rd.
// Optional build macro: TRACE_FILTER_EN restricts trace pushes to writes with
// FILT_LO <= mem_addr <= FILT_HI (the mailbox write is always traced).
module cpu_bus_monitor #(
  parameter int unsigned        ADDR_W       = 32,
  parameter int unsigned        DATA_W       = 32,
  parameter int unsigned        TRACE_DEPTH  = 16,
  parameter logic [ADDR_W-1:0]  MAILBOX_ADDR = 32'h0000_FFFC,
  parameter logic [DATA_W-1:0]  PASS_VALUE   = 32'h0000_0001,
  parameter int unsigned        TIMEOUT_CYC  = 100000,
  parameter int unsigned        CYC_W        = 32,
  parameter logic [ADDR_W-1:0]  FILT_LO      = 32'h0000_0000,
  parameter logic [ADDR_W-1:0]  FILT_HI      = 32'hFFFF_FFFF
) (
  input  logic                 clk_100M,
  input  logic                 clk_en,
  input  logic                 rst_n,
  cpu_bus_monitor_if.slave     bus,
  output logic                 done,
  output logic                 pass,
  output logic [DATA_W-1:0]    fail_code,
  output logic                 timeout,
  output logic [CYC_W-1:0]     cycle_cnt
);

  localparam int unsigned PtrW = $clog2(TRACE_DEPTH);
  localparam int unsigned CntW = $clog2(TRACE_DEPTH + 1);

  localparam logic [CntW-1:0]  DepthCnt    = CntW'(TRACE_DEPTH);
  localparam logic [CYC_W-1:0] TimeoutLast = CYC_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StDone    = 2'd1;
  localparam logic [1:0] StTimeout = 2'd2;

  // Elaboration-time parameter sanity checks.
  if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cpu_bus_monitor: TRACE_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("cpu_bus_monitor: TIMEOUT_CYC must be >= 1");
  end
  if (FILT_LO > FILT_HI) begin : g_bad_filter
    $error("cpu_bus_monitor: FILT_LO must not exceed FILT_HI");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [CYC_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [DATA_W-1:0] fail_code_q, fail_code_d;
  logic              timeout_q, timeout_d;

  logic [ADDR_W-1:0] addr_mem [TRACE_DEPTH];
  logic [DATA_W-1:0] data_mem [TRACE_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic in_run;
  logic mailbox_hit;
  logic trace_hit;
  logic push_req;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic drop;

  assign in_run      = (state_q == StRun);
  assign mailbox_hit = bus.wr_en && (bus.mem_addr == MAILBOX_ADDR);

`ifdef TRACE_FILTER_EN
  logic in_window;
  assign in_window = (bus.mem_addr >= FILT_LO) && (bus.mem_addr <= FILT_HI);
  // The mailbox write is traced even when it falls outside the window.
  assign trace_hit = bus.wr_en && (in_window || mailbox_hit);
`else
  assign trace_hit = bus.wr_en;
`endif

  assign push_req   = in_run && trace_hit;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DepthCnt);
  // A pop on an empty FIFO is ignored, so an empty push+pop is just a push.
  assign pop        = bus.trace_rd && !fifo_empty;
  // When full, a same-event pop frees the slot the push needs.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  // ---------------------------------------------------------------------------
  // Control FSM next state: RUN counts cycles until a mailbox write or timeout
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_code_d = fail_code_q;
    timeout_d   = timeout_q;
    case (state_q)
      StRun: begin
        if (!(&cycle_cnt_q)) begin
          cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
        end
        // Mailbox takes priority over a timeout on the same final event.
        if (mailbox_hit) begin
          state_d = StDone;
          done_d  = 1'b1;
          if (bus.w_data == PASS_VALUE) begin
            pass_d = 1'b1;
          end else begin
            fail_code_d = bus.w_data;
          end
        end else if (cycle_cnt_q == TimeoutLast) begin
          state_d   = StTimeout;
          timeout_d = 1'b1;
        end
      end
      StDone, StTimeout: begin
        // Terminal: results frozen until reset.
      end
      default: begin
        // Unreachable encoding; park it as terminal rather than restart.
        state_d = StDone;
      end
    endcase
  end

  // FSM and result registers; reset wins over clk_en
  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      state_q     <= StRun;
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_code_q <= '0;
      timeout_q   <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_code_q <= fail_code_d;
      timeout_q   <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Trace FIFO
  // ---------------------------------------------------------------------------

  // Next pointers, occupancy and sticky overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // FIFO bookkeeping registers; reset empties the FIFO
  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (clk_en) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset
  always_ff @(posedge clk_100M) begin
    if (rst_n && clk_en && push) begin
      addr_mem[wr_ptr_q] <= bus.mem_addr;
      data_mem[wr_ptr_q] <= bus.w_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.trace_valid = !fifo_empty;
  assign bus.trace_addr  = fifo_empty ? '0 : addr_mem[rd_ptr_q];
  assign bus.trace_data  = fifo_empty ? '0 : data_mem[rd_ptr_q];
  assign bus.trace_count = count_q;
  assign bus.trace_ovf   = ovf_q;

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = fail_code_q;
  assign timeout   = timeout_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_bus_monitor.sv
// Self-checking bench for cpu_bus_monitor (TRACE_DEPTH=4, TIMEOUT_CYC=50,
// filter window 0x100..0x1FF when TRACE_FILTER_EN is defined).
module tb_cpu_bus_monitor;

  localparam int unsigned Depth   = 4;
  localparam int unsigned ToCyc   = 50;
  localparam logic [31:0] Mbox    = 32'h0000_FFFC;
  localparam logic [31:0] PassVal = 32'h0000_0001;
`ifdef TRACE_FILTER_EN
  localparam bit FiltOn = 1'b1;
`else
  localparam bit FiltOn = 1'b0;
`endif

  logic        clk_100M;
  logic        clk_en;
  logic        rst_n;
  logic        done;
  logic        pass;
  logic [31:0] fail_code;
  logic        timeout;
  logic [31:0] cycle_cnt;

  cpu_bus_monitor_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) bus ();

  cpu_bus_monitor #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TRACE_DEPTH (Depth),
    .MAILBOX_ADDR(Mbox),
    .PASS_VALUE  (PassVal),
    .TIMEOUT_CYC (ToCyc),
    .CYC_W       (32),
    .FILT_LO     (32'h0000_0100),
    .FILT_HI     (32'h0000_01FF)
  ) dut (
    .clk_100M (clk_100M),
    .clk_en   (clk_en),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .done     (done),
    .pass     (pass),
    .fail_code(fail_code),
    .timeout  (timeout),
    .cycle_cnt(cycle_cnt)
  );

  initial clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model and trace scoreboard
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        sb[$];
  int          m_state;  // 0 run, 1 done, 2 timeout
  logic [31:0] m_cnt;
  bit          m_done, m_pass, m_to, m_ovf;
  logic [31:0] m_fail;

  typedef struct {
    bit          rst;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          rd;
    bit          e_done;
    bit          e_pass;
    logic [31:0] e_fail;
    int          e_count;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_state = 0;
    m_cnt   = '0;
    m_done  = 1'b0;
    m_pass  = 1'b0;
    m_to    = 1'b0;
    m_ovf   = 1'b0;
    m_fail  = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".done"},     32'(done),      32'(m_done));
    check({tag, ".pass"},     32'(pass),      32'(m_pass));
    check({tag, ".fail_code"}, fail_code,     m_fail);
    check({tag, ".timeout"},  32'(timeout),   32'(m_to));
    check({tag, ".cycle_cnt"}, cycle_cnt,     m_cnt);
    check({tag, ".count"},    32'(bus.trace_count), sb.size());
    check({tag, ".valid"},    32'(bus.trace_valid), 32'(sb.size() != 0));
    check({tag, ".ovf"},      32'(bus.trace_ovf),   32'(m_ovf));
    check({tag, ".head_addr"}, bus.trace_addr, (sb.size() != 0) ? sb[0].addr : 32'h0);
    check({tag, ".head_data"}, bus.trace_data, (sb.size() != 0) ? sb[0].data : 32'h0);
  endtask

  // Reset on one edge with the given clk_en; outputs must all read 0 after it.
  task automatic do_reset(input bit en);
    rst_n        = 1'b0;
    clk_en       = en;
    bus.wr_en    = 1'b1;
    bus.mem_addr = Mbox;
    bus.w_data   = 32'h1234;
    bus.trace_rd = 1'b1;
    @(posedge clk_100M);
    #1;
    bus.wr_en    = 1'b0;
    bus.trace_rd = 1'b0;
    model_reset();
    check_all("reset");
    rst_n  = 1'b1;
    clk_en = 1'b1;
  endtask

  // One enabled event; pops are compared against the scoreboard head.
  task automatic step(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input bit rd);
    ent_t e;
    bit   push_req;
    clk_en       = 1'b1;
    bus.wr_en    = wr;
    bus.mem_addr = addr;
    bus.w_data   = data;
    bus.trace_rd = rd;
    if (rd && sb.size() != 0) begin
      e = sb.pop_front();
      check("pop.valid", 32'(bus.trace_valid), 32'd1);
      check("pop.addr", bus.trace_addr, e.addr);
      check("pop.data", bus.trace_data, e.data);
    end
    push_req = (m_state == 0) && wr &&
               (!FiltOn || (addr >= 32'h100 && addr <= 32'h1FF) || addr == Mbox);
    if (m_state == 0) begin
      if (wr && addr == Mbox) begin
        m_state = 1;
        m_done  = 1'b1;
        if (data == PassVal) m_pass = 1'b1;
        else                 m_fail = data;
      end else if (m_cnt == ToCyc - 1) begin
        m_state = 2;
        m_to    = 1'b1;
      end
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    if (push_req) begin
      if (sb.size() < Depth) begin
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk_100M);
    #1;
    bus.wr_en    = 1'b0;
    bus.trace_rd = 1'b0;
    check_all("step");
  endtask

  logic [31:0] saved_cnt;

  initial begin
    rst_n        = 1'b0;
    clk_en       = 1'b0;
    bus.wr_en    = 1'b0;
    bus.mem_addr = '0;
    bus.w_data   = '0;
    bus.trace_rd = 1'b0;

    //            rst wr addr          data           rd done pass fail      cnt
    vecs[0] = '{1'b1, 1'b1, 32'h10,   32'hA,     1'b0, 1'b0, 1'b0, 32'h0,    1};
    vecs[1] = '{1'b0, 1'b1, 32'h14,   32'hB,     1'b0, 1'b0, 1'b0, 32'h0,    2};
    vecs[2] = '{1'b0, 1'b1, Mbox,     32'h1,     1'b0, 1'b1, 1'b1, 32'h0,    3};
    vecs[3] = '{1'b0, 1'b0, 32'h0,    32'h0,     1'b1, 1'b1, 1'b1, 32'h0,    2};
    vecs[4] = '{1'b0, 1'b0, 32'h0,    32'h0,     1'b1, 1'b1, 1'b1, 32'h0,    1};
    vecs[5] = '{1'b0, 1'b0, 32'h0,    32'h0,     1'b1, 1'b1, 1'b1, 32'h0,    0};
    vecs[6] = '{1'b0, 1'b0, 32'h0,    32'h0,     1'b1, 1'b1, 1'b1, 32'h0,    0};
    vecs[7] = '{1'b1, 1'b1, Mbox,     32'hDEAD,  1'b0, 1'b1, 1'b0, 32'hDEAD, 1};
    vecs[8] = '{1'b0, 1'b1, Mbox,     32'h1,     1'b0, 1'b1, 1'b0, 32'hDEAD, 1};
    vecs[9] = '{1'b0, 1'b0, 32'h0,    32'h0,     1'b1, 1'b1, 1'b0, 32'hDEAD, 0};

    // Table: PASS run with ordered drain, then FAIL run with a late PASS write
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst) do_reset(1'b1);
      step(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].rd);
      check("vec.done", 32'(done), 32'(vecs[i].e_done));
      check("vec.pass", 32'(pass), 32'(vecs[i].e_pass));
      check("vec.fail_code", fail_code, vecs[i].e_fail);
      check("vec.count", 32'(bus.trace_count), vecs[i].e_count);
      if (i == 2) check("vec.cycle_cnt", cycle_cnt, 32'd3);
    end
    check("fail_run.cycle_cnt", cycle_cnt, 32'd1);

    // Timeout after the 50th enabled cycle; later mailbox write ignored
    do_reset(1'b1);
    for (int i = 0; i < 49; i++) step(1'b0, 32'h0, 32'h0, 1'b0);
    check("to.pre_timeout", 32'(timeout), 32'd0);
    check("to.pre_cnt", cycle_cnt, 32'd49);
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check("to.timeout", 32'(timeout), 32'd1);
    check("to.cnt", cycle_cnt, 32'd50);
    step(1'b1, Mbox, 32'h1, 1'b0);
    check("to.late_done", 32'(done), 32'd0);
    check("to.no_push", 32'(bus.trace_count), 32'd0);
    check("to.frozen_cnt", cycle_cnt, 32'd50);

    // Mailbox on the final event beats the timeout
    do_reset(1'b1);
    for (int i = 0; i < 49; i++) step(1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, Mbox, 32'h1, 1'b0);
    check("race.done", 32'(done), 32'd1);
    check("race.pass", 32'(pass), 32'd1);
    check("race.timeout", 32'(timeout), 32'd0);
    check("race.cnt", cycle_cnt, 32'd50);

    // Overflow: six writes into four slots, then push+pop while full
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 32'h20 + 32'(4 * i), 32'(i + 1), 1'b0);
    check("ovf.count", 32'(bus.trace_count), 32'd4);
    check("ovf.flag", 32'(bus.trace_ovf), 32'd1);
    check("ovf.head", bus.trace_addr, 32'h20);
    step(1'b1, 32'h80, 32'h77, 1'b1);
    check("fullpp.count", 32'(bus.trace_count), 32'd4);
    check("fullpp.head", bus.trace_addr, 32'h24);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
    check("ovf.sticky", 32'(bus.trace_ovf), 32'd1);

    // Empty push+pop, clk_en freeze, then reset with clk_en low
    do_reset(1'b1);
    step(1'b1, 32'h30, 32'hC1, 1'b1);
    check("epp.count", 32'(bus.trace_count), 32'd1);
    step(1'b1, 32'h34, 32'hC2, 1'b0);
    saved_cnt = cycle_cnt;
    for (int i = 0; i < 10; i++) begin
      clk_en       = 1'b0;
      bus.wr_en    = 1'b1;
      bus.mem_addr = 32'h40 + 32'(i);
      bus.w_data   = 32'(i);
      bus.trace_rd = i[0];
      @(posedge clk_100M);
      #1;
    end
    clk_en       = 1'b1;
    bus.wr_en    = 1'b0;
    bus.trace_rd = 1'b0;
    check("cken.count", 32'(bus.trace_count), 32'd2);
    check("cken.cnt", cycle_cnt, saved_cnt);
    check_all("cken");
    for (int i = 0; i < 3; i++) step(1'b1, 32'h50 + 32'(i), 32'hE0 + 32'(i), 1'b0);
    step(1'b1, Mbox, 32'h55, 1'b0);
    check("mid.fail_code", fail_code, 32'h55);
    check("mid.ovf", 32'(bus.trace_ovf), 32'd1);
    do_reset(1'b0);
    check("rst_cken0.done", 32'(done), 32'd0);
    check("rst_cken0.count", 32'(bus.trace_count), 32'd0);
    check("rst_cken0.cnt", cycle_cnt, 32'd0);

    // Trace filter window (all writes traced when the filter is compiled out)
    do_reset(1'b1);
    step(1'b1, 32'h0F0, 32'h1, 1'b0);
    step(1'b1, 32'h100, 32'h2, 1'b0);
    step(1'b1, 32'h1FF, 32'h3, 1'b0);
    step(1'b1, 32'h200, 32'h4, 1'b0);
    step(1'b1, Mbox, 32'h1, 1'b0);
    check("filt.count", 32'(bus.trace_count), FiltOn ? 32'd3 : 32'd4);
    check("filt.head", bus.trace_addr, FiltOn ? 32'h100 : 32'h0F0);
    check("filt.ovf", 32'(bus.trace_ovf), FiltOn ? 32'd0 : 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
